// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, state encoding and byte-lane helpers for the load/store unit.
//   OP_LOAD / OP_STORE      : recognised major opcodes
//   F3_*                    : funct3 access size / signedness encodings
//   lsu_state_e             : controller FSM states
//   store_be / store_data   : lane enables and replicated data for a store
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_e;

    // Byte enables of a store; misaligned sizes never reach here.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3)
            F3_SB:   store_be = 4'b0001 << addr_lo;
            F3_SH:   store_be = 4'b0011 << {addr_lo[1], 1'b0};
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data across all lanes so the enabled lanes carry it.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            F3_SB:   store_data = {4{wdata[7:0]}};
            F3_SH:   store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load data alignment and extension.
//   rdata  : raw 32-bit word from memory
//   addr   : byte offset within the word
//   funct3 : load size / signedness
//   data   : right-aligned, sign- or zero-extended result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {24'h0, shifted[7:0]};
            F3_LHU:  data = {16'h0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between the pipeline and a
// req/gnt/rvalid memory port.
//   req_*      : pipeline request (accepted when req_valid && req_ready)
//   mem_*      : word-aligned memory request, held until mem_gnt; read data on mem_rvalid
//   rsp_*      : one-cycle completion pulse with extended load data or error flag
//   busy       : high outside IDLE, stalls the pipeline
// Errors (misalignment, illegal funct3/opcode) are decided at acceptance and
// complete without touching memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [6:0]        req_opcode,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic              busy
);

    lsu_state_e        state_q;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic [4:0]        rd_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;
    logic [4:0]        rsp_rd_q;
    logic              rsp_err_q;

    logic              req_is_load;
    logic              req_is_store;
    logic              req_f3_ok;
    logic              req_misalign;
    logic              req_err;
    logic [31:0]       load_data;

    // Request decode, evaluated on the live request so errors skip memory entirely.
    always_comb begin
        req_is_load  = (req_opcode == OP_LOAD);
        req_is_store = (req_opcode == OP_STORE);
        if (req_is_load) begin
            req_f3_ok = req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        end else begin
            req_f3_ok = req_funct3 inside {F3_SB, F3_SH, F3_SW};
        end
        // funct3[1:0] is the size for both loads and stores: 01 half, 10 word.
        req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err      = !(req_is_load || req_is_store) || !req_f3_ok || req_misalign;
    end

    lsu_load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (addr_lo_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            rd_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        rd_q      <= req_rd;
                        if (req_err) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_rd_q    <= req_is_load ? req_rd : 5'd0;
                        end else begin
                            state_q     <= StReq;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_is_store;
                            mem_be_q    <= req_is_store ?
                                           store_be(req_funct3, req_addr[1:0]) : 4'b1111;
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= req_is_store ? store_data(req_funct3, req_wdata) : '0;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= '0;
                            rsp_rd_q    <= '0;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mem_rvalid) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= load_data;
                        rsp_rd_q    <= rd_q;
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                    rsp_rd_q    <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_err   = rsp_err_q;

endmodule
